// File: rtl/qa_sched.sv
// Round-robin scheduler that shares one paced output channel between N_CH buffered producers.
// Words are issued one per GAP-cycle slot. The first overflow switches to a sticky error-code stream.
module qa_sched #(
    parameter int          WIDTH     = 32,
    parameter int          N_CH      = 4,
    parameter int          CH_W      = 2,
    parameter int          DEPTH     = 4,
    parameter int          GAP       = 64,
    parameter logic [31:0] ERRORCODE = 32'hDEADBEEF
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_CH*WIDTH-1:0]   in_data,
    input  logic [N_CH-1:0]         in_nd,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_nd,
    output logic [CH_W-1:0]         out_chan,
    output logic                    error,
    output logic [N_CH-1:0]         error_chan
);

    localparam int               AW       = $clog2(DEPTH);
    localparam int               GW       = $clog2(GAP);
    localparam logic [GW-1:0]    GAP_LOAD = GW'(GAP - 1);
    localparam logic [AW:0]      FULL_CNT = (AW + 1)'(DEPTH);
    localparam logic [WIDTH-1:0] ERR_WORD = WIDTH'(ERRORCODE);

    typedef enum logic [1:0] {IDLE, WAIT, ERR} state_t;

    state_t state, state_next;

    logic [WIDTH-1:0] mem [N_CH][DEPTH];
    logic [AW-1:0]    wr_ptr [N_CH];
    logic [AW-1:0]    rd_ptr [N_CH];
    logic [AW:0]      count [N_CH];
    logic [WIDTH-1:0] head [N_CH];

    logic [GW-1:0]    gap_cnt;
    logic [CH_W-1:0]  last_granted;

    logic [N_CH-1:0]  avail;
    logic [N_CH-1:0]  full;
    logic [N_CH-1:0]  push;
    logic [N_CH-1:0]  pop;
    logic [N_CH-1:0]  overflow;
    logic [CH_W:0]    pick;
    logic [CH_W:0]    err_pick;
    logic             issue_data;
    logic             issue_err;

    // First requesting channel strictly after 'last', wrapping; MSB of the result is the found flag.
    function automatic logic [CH_W:0] rr_pick(input logic [N_CH-1:0] req,
                                              input logic [CH_W-1:0] last);
        logic [CH_W:0] r;
        int            c;
        r = '0;
        for (int k = N_CH; k >= 1; k--) begin
            c = int'(last) + k;
            if (c >= N_CH) c = c - N_CH;
            if (req[c]) r = {1'b1, CH_W'(c)};
        end
        return r;
    endfunction

    function automatic logic [CH_W:0] lowest_set(input logic [N_CH-1:0] v);
        logic [CH_W:0] r;
        r = '0;
        for (int k = N_CH - 1; k >= 0; k--) begin
            if (v[k]) r = {1'b1, CH_W'(k)};
        end
        return r;
    endfunction

    // An empty FIFO with a push this cycle presents the incoming word as its head (bypass).
    always_comb begin
        avail = '0;
        full  = '0;
        for (int i = 0; i < N_CH; i++) begin
            full[i]  = (count[i] == FULL_CNT);
            avail[i] = (count[i] != '0) || in_nd[i];
            head[i]  = (count[i] == '0) ? in_data[i*WIDTH +: WIDTH] : mem[i][rd_ptr[i]];
        end
    end

    assign pick     = rr_pick(avail, last_granted);
    assign err_pick = lowest_set(error_chan);

    always_comb begin
        state_next = state;
        issue_data = 1'b0;
        issue_err  = 1'b0;
        pop        = '0;
        case (state)
            IDLE: begin
                if (error) begin
                    state_next = ERR;
                end else if (pick[CH_W]) begin
                    issue_data = 1'b1;
                    pop        = N_CH'(1) << pick[CH_W-1:0];
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (error) begin
                    state_next = ERR;
                end else if (gap_cnt <= GW'(1)) begin
                    state_next = IDLE;
                end
            end
            ERR: begin
                if (gap_cnt == '0) issue_err = 1'b1;
            end
            default: state_next = IDLE;
        endcase
    end

    // A push into a full FIFO survives only if the same FIFO is popped in that cycle.
    always_comb begin
        push     = '0;
        overflow = '0;
        for (int i = 0; i < N_CH; i++) begin
            push[i]     = in_nd[i] && (!full[i] || pop[i]);
            overflow[i] = in_nd[i] && full[i] && !pop[i];
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < N_CH; i++) begin
            if (push[i]) mem[i][wr_ptr[i]] <= in_data[i*WIDTH +: WIDTH];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            gap_cnt      <= '0;
            last_granted <= CH_W'(N_CH - 1);
            out_data     <= '0;
            out_nd       <= 1'b0;
            out_chan     <= '0;
            error        <= 1'b0;
            error_chan   <= '0;
            for (int i = 0; i < N_CH; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                count[i]  <= '0;
            end
        end else begin
            state  <= state_next;
            out_nd <= issue_data || issue_err;

            if (issue_data || issue_err) begin
                gap_cnt <= GAP_LOAD;
            end else if (gap_cnt != '0) begin
                gap_cnt <= gap_cnt - GW'(1);
            end

            if (issue_data) begin
                out_data     <= head[pick[CH_W-1:0]];
                out_chan     <= pick[CH_W-1:0];
                last_granted <= pick[CH_W-1:0];
            end else if (issue_err) begin
                out_data <= ERR_WORD;
                out_chan <= err_pick[CH_W-1:0];
            end

            error_chan <= error_chan | overflow;
            if (|overflow) error <= 1'b1;

            for (int i = 0; i < N_CH; i++) begin
                if (push[i]) wr_ptr[i] <= wr_ptr[i] + AW'(1);
                if (pop[i])  rd_ptr[i] <= rd_ptr[i] + AW'(1);
                if (push[i] && !pop[i]) begin
                    count[i] <= count[i] + (AW + 1)'(1);
                end else if (!push[i] && pop[i]) begin
                    count[i] <= count[i] - (AW + 1)'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_qa_sched.sv
// Scoreboard bench for qa_sched: directed pushes queue hand-computed (cycle, channel, word)
// expectations, and an independent monitor checks every out_nd strobe against them.
module tb_qa_sched;

    localparam int WIDTH = 32;
    localparam int N_CH  = 4;
    localparam int CH_W  = 2;
    localparam int DEPTH = 4;
    localparam int GAP   = 64;

    logic                  clk = 1'b0;
    logic                  reset = 1'b1;
    logic [N_CH*WIDTH-1:0] in_data = '0;
    logic [N_CH-1:0]       in_nd = '0;
    logic [WIDTH-1:0]      out_data;
    logic                  out_nd;
    logic [CH_W-1:0]       out_chan;
    logic                  error;
    logic [N_CH-1:0]       error_chan;

    typedef struct {
        int          at;
        int          chan;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;
    int   e;

    qa_sched #(
        .WIDTH(WIDTH), .N_CH(N_CH), .CH_W(CH_W), .DEPTH(DEPTH), .GAP(GAP),
        .ERRORCODE(32'hDEADBEEF)
    ) dut (
        .clk(clk),
        .reset(reset),
        .in_data(in_data),
        .in_nd(in_nd),
        .out_data(out_data),
        .out_nd(out_nd),
        .out_chan(out_chan),
        .error(error),
        .error_chan(error_chan)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s at cycle %0d: got %h, required %h", name, cyc, actual, expected);
        end
    endtask

    task automatic next_cycle();
        @(negedge clk);
        in_nd = '0;
    endtask

    task automatic apply_stimulus(input int ch, input logic [31:0] w);
        in_nd[ch] = 1'b1;
        in_data[ch*WIDTH +: WIDTH] = w;
    endtask

    task automatic expect_word(input int at, input int ch, input logic [31:0] w);
        exp_t x;
        x.at   = at;
        x.chan = ch;
        x.data = w;
        sb.push_back(x);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        in_nd = '0;
        @(negedge clk);
        @(negedge clk);
        sb.delete();
        reset = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 2000 && sb.size() != 0; i++) next_cycle();
        check_output(name, sb.size(), 0);
    endtask

    task automatic settle();
        repeat (70) next_cycle();
    endtask

    // Monitor: every strobe must match the oldest outstanding expectation, including its cycle.
    always @(negedge clk) begin
        if (out_nd === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_out at cycle %0d: got chan=%0d data=%h, required no output",
                         cyc, out_chan, out_data);
            end else begin
                mon_e = sb.pop_front();
                check_output("out_cycle", cyc, mon_e.at);
                check_output("out_chan", out_chan, mon_e.chan);
                check_output("out_data", out_data, mon_e.data);
            end
        end
    end

    initial begin
        repeat (3) @(negedge clk);
        check_output("reset_out_nd", out_nd, 0);
        check_output("reset_out_data", out_data, 0);
        check_output("reset_out_chan", out_chan, 0);
        check_output("reset_error", error, 0);
        check_output("reset_error_chan", error_chan, 0);
        reset = 1'b0;

        // Single word through the bypass path.
        next_cycle();
        apply_stimulus(2, 32'h12345678);
        e = cyc + 1;
        expect_word(e, 2, 32'h12345678);
        wait_drain("t1_drain");
        settle();

        // Fairness from reset priority, then from last_granted = 1.
        do_reset();
        next_cycle();
        for (int k = 0; k < 4; k++) apply_stimulus(k, 32'hA0 + k);
        e = cyc + 1;
        for (int k = 0; k < 4; k++) expect_word(e + 64*k, k, 32'hA0 + k);
        wait_drain("t2a_drain");
        settle();

        next_cycle();
        apply_stimulus(1, 32'hB1);
        e = cyc + 1;
        expect_word(e, 1, 32'hB1);
        wait_drain("t2b_drain");
        settle();

        next_cycle();
        for (int k = 0; k < 4; k++) apply_stimulus(k, 32'hC0 + k);
        e = cyc + 1;
        expect_word(e,       2, 32'hC2);
        expect_word(e + 64,  3, 32'hC3);
        expect_word(e + 128, 0, 32'hC0);
        expect_word(e + 192, 1, 32'hC1);
        wait_drain("t2c_drain");
        settle();

        // Fill ch1 with four back-to-back words: the first pop makes room.
        do_reset();
        next_cycle();
        e = cyc + 1;
        for (int k = 0; k < 4; k++) begin
            apply_stimulus(1, 32'h11110000 + k);
            expect_word(e + 64*k, 1, 32'h11110000 + k);
            next_cycle();
        end
        check_output("t3_error", error, 0);
        check_output("t3_error_chan", error_chan, 0);
        wait_drain("t3_drain");
        check_output("t3_error_end", error, 0);
        settle();

        // Overflow ch3 with six words, then expect the error-code stream.
        do_reset();
        next_cycle();
        e = cyc + 1;
        for (int k = 0; k < 6; k++) begin
            if (k == 5) check_output("t4_error_before", error, 0);
            apply_stimulus(3, 32'h33330000 + k);
            if (k == 0) expect_word(e, 3, 32'h33330000);
            next_cycle();
        end
        check_output("t4_error", error, 1);
        check_output("t4_error_chan", error_chan, 4'b1000);
        expect_word(e + 64,  3, 32'hDEADBEEF);
        expect_word(e + 128, 3, 32'hDEADBEEF);
        expect_word(e + 192, 3, 32'hDEADBEEF);
        wait_drain("t4_drain");
        check_output("t4_error_chan_sticky", error_chan, 4'b1000);

        // ch0 full when a slot opens together with another push: no overflow, nothing lost.
        do_reset();
        next_cycle();
        e = cyc + 1;
        for (int k = 0; k < 5; k++) begin
            apply_stimulus(0, 32'h50500000 + k);
            expect_word(e + 64*k, 0, 32'h50500000 + k);
            next_cycle();
        end
        while (cyc < e + 63) next_cycle();
        apply_stimulus(0, 32'h50505050);
        expect_word(e + 320, 0, 32'h50505050);
        next_cycle();
        check_output("t5_error_early", error, 0);
        wait_drain("t5_drain");
        check_output("t5_error", error, 0);
        check_output("t5_error_chan", error_chan, 0);
        settle();

        // Reset while three words are queued and the gap is running.
        do_reset();
        next_cycle();
        e = cyc + 1;
        for (int k = 0; k < 4; k++) begin
            apply_stimulus(2, 32'h60600000 + k);
            if (k == 0) expect_word(e, 2, 32'h60600000);
            next_cycle();
        end
        while (cyc < e + 9) next_cycle();
        reset = 1'b1;
        @(negedge clk);
        check_output("t6_out_nd", out_nd, 0);
        check_output("t6_out_data", out_data, 0);
        check_output("t6_out_chan", out_chan, 0);
        check_output("t6_error", error, 0);
        check_output("t6_error_chan", error_chan, 0);
        reset = 1'b0;
        apply_stimulus(1, 32'h77777777);
        expect_word(cyc + 1, 1, 32'h77777777);
        next_cycle();
        wait_drain("t6_drain");
        repeat (300) next_cycle();
        check_output("final_queue_empty", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
